// File: rtl/ddr_local_responder_if.sv
// ============================================================================
// Module      : ddr_local_responder_if
// Description : DDR local (Avalon-style) request/response bundle between the
//               SoC-side initiator and the local responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ddr_local_responder_if #(
    parameter int DDR_ADDR_WIDTH = 26,
    parameter int DDR_DATA_WIDTH = 128
);
    logic                      local_init_done;
    logic [DDR_ADDR_WIDTH-1:0] local_address;
    logic                      local_burstbegin;
    logic                      local_ready;
    logic                      local_read_req;
    logic [DDR_DATA_WIDTH-1:0] local_rdata;
    logic                      local_rdata_valid;
    logic                      local_write_req;
    logic [DDR_DATA_WIDTH-1:0] local_wdata;
    logic [15:0]               wr_count;
    logic [15:0]               rd_count;
    logic                      proto_err;

    modport master (
        input  local_init_done, local_ready, local_rdata, local_rdata_valid,
               wr_count, rd_count, proto_err,
        output local_address, local_burstbegin, local_read_req,
               local_write_req, local_wdata
    );

    modport slave (
        output local_init_done, local_ready, local_rdata, local_rdata_valid,
               wr_count, rd_count, proto_err,
        input  local_address, local_burstbegin, local_read_req,
               local_write_req, local_wdata
    );
endinterface

`default_nettype wire

// File: rtl/ddr_local_responder.sv
// ============================================================================
// Module      : ddr_local_responder
// Description : Stand-in for the DDR controller: serves single-beat reads and
//               writes from an on-chip array with fixed, parameterised latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_local_responder #(
    parameter int DDR_ADDR_WIDTH = 26,
    parameter int DDR_DATA_WIDTH = 128,
    parameter int MEM_DEPTH_LOG2 = 8,
    parameter int INIT_CYCLES    = 16,
    parameter int READ_LATENCY   = 4,
    parameter int WRITE_GAP      = 1
) (
    input  logic                 phy_clk,
    input  logic                 rst,
    ddr_local_responder_if.slave bus
);

    localparam int                 c_cnt_w     = 16;
    localparam int                 c_mem_words = 1 << MEM_DEPTH_LOG2;
    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_init_last = c_cnt_w'(INIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_rd_load   = c_cnt_w'(READ_LATENCY - 1);
    localparam logic [c_cnt_w-1:0] c_gap_load  = c_cnt_w'((WRITE_GAP > 0) ? WRITE_GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_READY   = 2'd1,
        S_WR_GAP  = 2'd2,
        S_RD_WAIT = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [c_cnt_w-1:0]        r_cnt;
    logic [c_cnt_w-1:0]        w_cnt_nxt;
    logic [MEM_DEPTH_LOG2-1:0] w_idx;
    logic                      w_wr_accept;
    logic                      w_rd_accept;
    logic                      w_load_rdata;
    logic [DDR_DATA_WIDTH-1:0] r_mem [c_mem_words];
    logic [DDR_DATA_WIDTH-1:0] r_rd_hold;
    logic [DDR_DATA_WIDTH-1:0] r_rdata;
    logic [15:0]               r_wr_count;
    logic [15:0]               r_rd_count;
    logic                      r_proto_err;
    logic                      w_unused;

    assign w_idx       = bus.local_address[MEM_DEPTH_LOG2-1:0];
    assign w_wr_accept = (r_state == S_READY) && bus.local_write_req;
    assign w_rd_accept = (r_state == S_READY) && bus.local_read_req && !bus.local_write_req;

    // Load the output register on the edge that enters the final RD_WAIT cycle.
    assign w_load_rdata = (w_rd_accept && (READ_LATENCY == 1)) ||
                          ((r_state == S_RD_WAIT) && (r_cnt == c_one));

    assign w_unused = ^{bus.local_burstbegin,
                        bus.local_address[DDR_ADDR_WIDTH-1:MEM_DEPTH_LOG2]};

    always_ff @(posedge phy_clk) begin
        if (rst) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_INIT: begin
                if (r_cnt == c_init_last) begin
                    w_state_nxt = S_READY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
            S_READY: begin
                if (w_wr_accept) begin
                    if (WRITE_GAP > 0) begin
                        w_state_nxt = S_WR_GAP;
                        w_cnt_nxt   = c_gap_load;
                    end
                end else if (w_rd_accept) begin
                    w_state_nxt = S_RD_WAIT;
                    w_cnt_nxt   = c_rd_load;
                end
            end
            S_WR_GAP, S_RD_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_READY;
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Array and read holding register are deliberately left out of reset.
    always_ff @(posedge phy_clk) begin
        if (w_wr_accept) begin
            r_mem[w_idx] <= bus.local_wdata;
        end
        if (w_rd_accept) begin
            r_rd_hold <= r_mem[w_idx];
        end
    end

    always_ff @(posedge phy_clk) begin
        if (rst) begin
            r_wr_count  <= '0;
            r_rd_count  <= '0;
            r_proto_err <= 1'b0;
            r_rdata     <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (w_rd_accept) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (w_wr_accept && bus.local_read_req) begin
                r_proto_err <= 1'b1;
            end
            if (w_load_rdata) begin
                r_rdata <= (READ_LATENCY == 1) ? r_mem[w_idx] : r_rd_hold;
            end
        end
    end

    assign bus.local_init_done   = (r_state != S_INIT);
    assign bus.local_ready       = (r_state == S_READY);
    assign bus.local_rdata_valid = (r_state == S_RD_WAIT) && (r_cnt == '0);
    assign bus.local_rdata       = r_rdata;
    assign bus.wr_count          = r_wr_count;
    assign bus.rd_count          = r_rd_count;
    assign bus.proto_err         = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_ddr_local_responder.sv
// ============================================================================
// Module      : tb_ddr_local_responder
// Description : Scoreboard bench for ddr_local_responder (gap=1 and gap=0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ddr_local_responder;

    localparam int AW = 26;
    localparam int DW = 128;
    localparam int RL = 4;

    localparam logic [DW-1:0] D_WR1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [DW-1:0] D_A   = 128'hAAAA0000AAAA1111AAAA2222AAAA3333;
    localparam logic [DW-1:0] D_B   = 128'hBBBB4444BBBB5555BBBB6666BBBB7777;
    localparam logic [DW-1:0] D_C   = 128'hC0FFEE00C0FFEE11C0FFEE22C0FFEE33;

    logic phy_clk = 1'b0;
    logic rst     = 1'b1;
    always #5 phy_clk = ~phy_clk;

    ddr_local_responder_if #(.DDR_ADDR_WIDTH(AW), .DDR_DATA_WIDTH(DW)) bus  ();
    ddr_local_responder_if #(.DDR_ADDR_WIDTH(AW), .DDR_DATA_WIDTH(DW)) bus2 ();

    ddr_local_responder #(
        .DDR_ADDR_WIDTH(AW), .DDR_DATA_WIDTH(DW), .MEM_DEPTH_LOG2(8),
        .INIT_CYCLES(16), .READ_LATENCY(RL), .WRITE_GAP(1)
    ) dut (.phy_clk(phy_clk), .rst(rst), .bus(bus.slave));

    ddr_local_responder #(
        .DDR_ADDR_WIDTH(AW), .DDR_DATA_WIDTH(DW), .MEM_DEPTH_LOG2(8),
        .INIT_CYCLES(16), .READ_LATENCY(RL), .WRITE_GAP(0)
    ) dut2 (.phy_clk(phy_clk), .rst(rst), .bus(bus2.slave));

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    int     exp_wr   = 0;
    int     exp_rd   = 0;

    typedef struct {
        logic [DW-1:0] data;
        longint        due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always @(posedge phy_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every data return must match the oldest expected read, on time.
    always @(negedge phy_clk) begin
        if (bus.local_rdata_valid !== 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rdata_valid_unexpected: got %b expected 0 (cycle %0d)",
                         bus.local_rdata_valid, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("rdata", bus.local_rdata, mon_e.data);
                check("rdata_latency_cycle", DW'(cyc), DW'(mon_e.due));
            end
        end
        if (bus2.local_rdata_valid !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL dut2_rdata_valid_unexpected: got %b expected 0", bus2.local_rdata_valid);
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.local_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge phy_clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got local_ready=0 expected 1 within 200 cycles");
        end
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bit ok;
        bus.local_address   = addr;
        bus.local_wdata     = data;
        bus.local_write_req = 1'b1;
        wait_ready(ok);
        if (ok) exp_wr++;
        @(negedge phy_clk);
        bus.local_write_req = 1'b0;
        check1("write_gap_ready_low", bus.local_ready, 1'b0);
        @(negedge phy_clk);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data);
        bit   ok;
        exp_t e;
        bus.local_address  = addr;
        bus.local_read_req = 1'b1;
        wait_ready(ok);
        if (ok) begin
            e.data = exp_data;
            e.due  = cyc + RL;
            sb.push_back(e);
            exp_rd++;
        end
        repeat (RL) @(negedge phy_clk);
        bus.local_read_req = 1'b0;
        @(negedge phy_clk);
        check1("ready_after_read", bus.local_ready, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int ready_low;

        bus.local_address    = '0;
        bus.local_burstbegin = 1'b0;
        bus.local_read_req   = 1'b0;
        bus.local_write_req  = 1'b0;
        bus.local_wdata      = '0;
        bus2.local_address    = '0;
        bus2.local_burstbegin = 1'b0;
        bus2.local_read_req   = 1'b0;
        bus2.local_write_req  = 1'b0;
        bus2.local_wdata      = '0;

        // Reset values
        repeat (3) @(negedge phy_clk);
        check1("rst_init_done", bus.local_init_done, 1'b0);
        check1("rst_ready", bus.local_ready, 1'b0);
        check("rst_rdata", bus.local_rdata, '0);
        check1("rst_rdata_valid", bus.local_rdata_valid, 1'b0);
        check("rst_wr_count", DW'(bus.wr_count), '0);
        check("rst_rd_count", DW'(bus.rd_count), '0);
        check1("rst_proto_err", bus.proto_err, 1'b0);

        // Init: cycle 0 is the first cycle with rst low; ready at cycle 16
        rst = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            check1("init_ready", bus.local_ready, (k == 16));
            check1("init_done", bus.local_init_done, (k == 16));
            if (k < 16) @(negedge phy_clk);
        end
        check1("init_rdata_valid", bus.local_rdata_valid, 1'b0);
        check("init_wr_count", DW'(bus.wr_count), '0);

        // Write then read
        do_write(26'h5, D_WR1);
        check("wr_count_after_write", DW'(bus.wr_count), DW'(exp_wr));
        do_read(26'h5, D_WR1);
        check("rd_count_after_read", DW'(bus.rd_count), DW'(exp_rd));
        check("wr_count_after_read", DW'(bus.wr_count), 128'd1);

        // Aliasing: 0x105 and 0x005 share index 5
        do_write(26'h105, D_A);
        do_write(26'h005, D_B);
        do_read(26'h105, D_B);
        repeat (3) @(negedge phy_clk);
        check("rdata_holds", bus.local_rdata, D_B);

        // Simultaneous read and write: write wins, proto_err set
        bus.local_address   = 26'h20;
        bus.local_wdata     = D_C;
        bus.local_read_req  = 1'b1;
        bus.local_write_req = 1'b1;
        wait_ready(ok);
        if (ok) exp_wr++;
        @(negedge phy_clk);
        bus.local_read_req  = 1'b0;
        bus.local_write_req = 1'b0;
        check1("simul_proto_err", bus.proto_err, 1'b1);
        check("simul_rd_count", DW'(bus.rd_count), DW'(exp_rd));
        check("simul_wr_count", DW'(bus.wr_count), DW'(exp_wr));
        repeat (6) @(negedge phy_clk);
        do_read(26'h20, D_C);
        check1("proto_err_sticky", bus.proto_err, 1'b1);

        // Reset two cycles after a read is accepted: the return is dropped
        bus.local_address  = 26'h5;
        bus.local_read_req = 1'b1;
        wait_ready(ok);
        @(negedge phy_clk);
        @(negedge phy_clk);
        rst                = 1'b1;
        bus.local_read_req = 1'b0;
        @(negedge phy_clk);
        check1("midrst_init_done", bus.local_init_done, 1'b0);
        check1("midrst_ready", bus.local_ready, 1'b0);
        check("midrst_wr_count", DW'(bus.wr_count), '0);
        check("midrst_rd_count", DW'(bus.rd_count), '0);
        check1("midrst_proto_err", bus.proto_err, 1'b0);
        repeat (4) @(negedge phy_clk);
        rst    = 1'b0;
        exp_wr = 0;
        exp_rd = 0;
        @(negedge phy_clk);
        do_read(26'h5, D_B);
        check("reinit_rd_count", DW'(bus.rd_count), 128'd1);

        // Counter wrap on the gapless instance
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus2.local_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge phy_clk);
        end
        check1("dut2_ready_before_wrap", ok, 1'b1);
        bus2.local_address   = 26'h7;
        bus2.local_wdata     = D_A;
        bus2.local_write_req = 1'b1;
        ready_low = 0;
        for (int i = 1; i <= 65536; i++) begin
            @(negedge phy_clk);
            if (bus2.local_ready !== 1'b1) ready_low++;
            if (i == 1)     check("wrap_count_1", DW'(bus2.wr_count), 128'd1);
            if (i == 65535) check("wrap_count_ffff", DW'(bus2.wr_count), 128'hFFFF);
            if (i == 65536) check("wrap_count_0", DW'(bus2.wr_count), 128'd0);
        end
        bus2.local_write_req = 1'b0;
        check("wrap_ready_low_cycles", DW'(ready_low), '0);
        @(negedge phy_clk);
        check("wrap_count_stable", DW'(bus2.wr_count), 128'd0);

        repeat (8) @(negedge phy_clk);
        check("scoreboard_drained", DW'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
